rgb_ac1c2_seq: RTL and testbench
================================

# rgb_ac1c2_seq

Time-multiplexed controller and datapath for the RGB→AC1C2 colour transform. It accepts one 8-bit RGB pixel per valid/ready handshake and sequences a single shared 16×9 signed multiplier through nine multiply-accumulate cycles to produce A, C1 and C2. It holds the 3×3 coefficient matrix in a writable register bank, loaded over a simple config port. It sits between the pixel source and the downstream AC1C2 consumer, and replaces three parallel fully-combinational dot products with one sequenced MAC.

## Interface
- Parameters: none. All widths are fixed.
- i_clk  in  1  Single clock. All state changes on the rising edge.
- i_rst_n  in  1  Asynchronous, active-low reset.
- i_cfg_we  in  1  Coefficient write strobe.
- i_cfg_addr  in  4  Coefficient index. 0..8 = m11,m12,m13,m21,…,m33 (row-major). 9..15 are ignored.
- i_cfg_data  in  16  Signed coefficient, Q3.13.
- o_cfg_err  out  1  One-cycle pulse when a write is rejected because the block is busy.
- i_valid  in  1  Input pixel valid.
- o_ready  out  1  Block can accept a pixel. Registered.
- i_R, i_G, i_B  in  8 each  Unsigned pixel components.
- o_valid  out  1  Result valid.
- i_ready  in  1  Downstream accepts the result.
- o_A, o_C1, o_C2  out  32 each  Results, formatted as {4× sign, acc[24:0], 3'b0}.
- o_busy  out  1  High in any state other than IDLE.

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: latch R,G,B into internal registers, clear the three 25-bit accumulators, set k=0, go to MAC.
- MAC:
  - Runs nine cycles, k=0..8. row=k/3, col=k%3.
  - Each cycle: acc[row] += $signed(coef[k]) × $signed({1'b0, pix[col]}), where pix = {R,G,B}.
  - The product is 25 bits signed. The accumulator wraps modulo 2^25 in two's complement; there is no saturation.
  - After k=8: register the outputs from the accumulators, set o_valid=1, go to DONE.
- DONE:
  - o_valid=1. o_A/o_C1/o_C2 are held stable.
  - On i_ready=1: clear o_valid, go to IDLE.
  - The output registers keep their last value after o_valid drops.
- o_ready is low in MAC and DONE. A pixel presented then is not accepted; the source must hold it.
- Config writes:
  - Accepted only in IDLE, when the address is 0..8.
  - A write in MAC or DONE is dropped and o_cfg_err pulses for one cycle.
  - A write to address 9..15 is ignored silently.
  - If a write and a pixel acceptance occur in the same IDLE cycle, the write lands first. The accepted pixel uses the new coefficient.
- Coefficients are read only during MAC. A pixel always uses one consistent coefficient set.

## Timing
- Reset (async assert, i_rst_n=0):
  - FSM=IDLE.
  - o_ready=0, o_valid=0, o_busy=0, o_cfg_err=0.
  - o_A=o_C1=o_C2=0.
  - All nine coefficients=0. Pixel registers and accumulators=0.
- o_ready rises on the first clock edge after i_rst_n deasserts.
- Reset asserted mid-MAC or in DONE aborts the pixel immediately. No partial result is ever presented.
- Latency: pixel handshake at edge N. MAC occupies cycles N+1..N+9. o_valid is high from cycle N+10.
- Throughput with i_ready tied high: one pixel per 11 cycles (handshake N+10, back to IDLE and o_ready=1 at N+11).
- Backpressure: o_valid stays high and the outputs are frozen for any number of cycles with i_ready=0.
- o_cfg_err is registered. It is high in the cycle after the rejected write.

## Test plan
- Coefficient mapping and positive result:
  - Stimulus: load m11=1, m12=2, m13=3 (16'h0001/0002/0003); send R=10, G=20, B=30.
  - Required: o_valid exactly 10 cycles after the handshake; A=140, so o_A=32'h0000_0460.
- Negative coefficient, sign extension:
  - Stimulus: m21=16'hFFFF, m22=m23=0; same pixel.
  - Required: C1=−10, o_C1=32'hFFFF_FFB0.
- Wrap-around:
  - Stimulus: m31=m32=m33=16'h7FFF; R=G=B=255.
  - Required: 25-bit acc=−8487677 (25066755 wrapped mod 2^25); o_C2 = −67901416 as signed 32-bit.
- Backpressure and throughput:
  - Stimulus: four back-to-back pixels with i_ready=1.
  - Required: accepts every 11 cycles.
  - Then hold i_ready=0 for 5 cycles in DONE.
  - Required: outputs stable, o_ready=0, the pending input not accepted until IDLE.
- Busy config rejection:
  - Stimulus: write m11=16'h0010 during MAC.
  - Required: o_cfg_err pulses once; current and next pixel use the old m11; a later IDLE write takes effect.
- Reset mid-operation:
  - Stimulus: drop i_rst_n during MAC cycle 5.
  - Required: all outputs 0 and FSM in IDLE immediately. After release, o_ready=1 one edge later; a new pixel yields all-zero results, since the coefficients were cleared.

Source files
------------

// File: rtl/rgb_ac1c2_seq.sv
`default_nettype none
// ============================================================================
// Module   : rgb_ac1c2_seq
// Purpose  : Sequenced RGB -> AC1C2 colour transform. One shared 16x9 signed
//            multiplier is stepped through nine multiply-accumulate cycles
//            per pixel. A 3x3 Q3.13 coefficient bank is written over a
//            simple config port while the block is idle.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_ac1c2_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_we,
  input  logic [3:0]  i_cfg_addr,
  input  logic [15:0] i_cfg_data,
  output logic        o_cfg_err,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [7:0]  i_R,
  input  logic [7:0]  i_G,
  input  logic [7:0]  i_B,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_A,
  output logic [31:0] o_C1,
  output logic [31:0] o_C2,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_K   = 4'd8;
  localparam logic [3:0] c_NUM_COEF = 4'd9;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_mac_last;

  logic [3:0]         r_k;
  logic signed [15:0] r_coef [0:8];
  logic [7:0]         r_pix  [0:2];
  logic signed [24:0] r_acc  [0:2];
  logic               r_ready;
  logic               r_valid;
  logic               r_cfg_err;
  logic [31:0]        r_a;
  logic [31:0]        r_c1;
  logic [31:0]        r_c2;

  logic               w_cfg_hit;
  logic               w_cfg_wr;
  logic               w_cfg_rej;
  logic [1:0]         w_row;
  logic [1:0]         w_col;
  logic [7:0]         w_pix;
  logic signed [15:0] w_coef;
  logic signed [24:0] w_acc_sel;
  logic signed [24:0] w_coef_ext;
  logic signed [24:0] w_pix_ext;
  logic signed [24:0] w_prod;
  logic signed [24:0] w_acc_sum;
  logic signed [24:0] w_final [0:2];

  // Result word: sign-extended accumulator scaled by 8.
  function automatic logic [31:0] f_fmt(input logic signed [24:0] a);
    return {{4{a[24]}}, a, 3'b000};
  endfunction

  // Coefficient writes: only in-range addresses matter; busy writes are rejected.
  assign w_cfg_hit = i_cfg_we && (i_cfg_addr < c_NUM_COEF);
  assign w_cfg_wr  = w_cfg_hit && (r_state == S_IDLE);
  assign w_cfg_rej = w_cfg_hit && (r_state != S_IDLE);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mac_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (r_k == c_LAST_K) begin
          w_mac_last  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Map step k onto (row, col) of the coefficient matrix.
  always_comb begin
    w_row = 2'd0;
    w_col = 2'd0;
    case (r_k)
      4'd0: begin w_row = 2'd0; w_col = 2'd0; end
      4'd1: begin w_row = 2'd0; w_col = 2'd1; end
      4'd2: begin w_row = 2'd0; w_col = 2'd2; end
      4'd3: begin w_row = 2'd1; w_col = 2'd0; end
      4'd4: begin w_row = 2'd1; w_col = 2'd1; end
      4'd5: begin w_row = 2'd1; w_col = 2'd2; end
      4'd6: begin w_row = 2'd2; w_col = 2'd0; end
      4'd7: begin w_row = 2'd2; w_col = 2'd1; end
      4'd8: begin w_row = 2'd2; w_col = 2'd2; end
      default: begin w_row = 2'd0; w_col = 2'd0; end
    endcase
  end

  // Operand selection for the shared multiplier and the active accumulator.
  always_comb begin
    w_pix     = r_pix[0];
    w_acc_sel = r_acc[0];
    case (w_col)
      2'd1:    w_pix = r_pix[1];
      2'd2:    w_pix = r_pix[2];
      default: w_pix = r_pix[0];
    endcase
    case (w_row)
      2'd1:    w_acc_sel = r_acc[1];
      2'd2:    w_acc_sel = r_acc[2];
      default: w_acc_sel = r_acc[0];
    endcase
  end

  // k never exceeds 8 while the multiplier result is consumed.
  assign w_coef     = r_coef[r_k];
  assign w_coef_ext = {{9{w_coef[15]}}, w_coef};
  assign w_pix_ext  = {17'd0, w_pix};
  // The true product always fits in 25 bits; accumulation wraps mod 2^25.
  assign w_prod     = w_coef_ext * w_pix_ext;
  assign w_acc_sum  = w_acc_sel + w_prod;

  // Accumulator values after this cycle's MAC, used for both update and result capture.
  for (genvar gi = 0; gi < 3; gi++) begin : g_final
    assign w_final[gi] = (w_row == 2'(gi)) ? w_acc_sum : r_acc[gi];
  end

  // Datapath: coefficient bank, pixel latch, step counter, accumulators, results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 9; i++) r_coef[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        r_pix[i] <= '0;
        r_acc[i] <= '0;
      end
      r_k  <= '0;
      r_a  <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
    end else begin
      // A write in the same cycle as pixel acceptance is visible from the first MAC.
      if (w_cfg_wr) r_coef[i_cfg_addr] <= i_cfg_data;
      if (w_accept) begin
        r_pix[0] <= i_R;
        r_pix[1] <= i_G;
        r_pix[2] <= i_B;
        for (int i = 0; i < 3; i++) r_acc[i] <= '0;
        r_k <= '0;
      end else if (r_state == S_MAC) begin
        for (int i = 0; i < 3; i++) r_acc[i] <= w_final[i];
        r_k <= r_k + 4'd1;
      end
      if (w_mac_last) begin
        r_a  <= f_fmt(w_final[0]);
        r_c1 <= f_fmt(w_final[1]);
        r_c2 <= f_fmt(w_final[2]);
      end
    end
  end

  // Handshake flags and config error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_ready   <= (w_state_nxt == S_IDLE);
      r_valid   <= (w_state_nxt == S_DONE);
      r_cfg_err <= w_cfg_rej;
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_valid;
  assign o_cfg_err = r_cfg_err;
  assign o_busy    = (r_state != S_IDLE);
  assign o_A       = r_a;
  assign o_C1      = r_c1;
  assign o_C2      = r_c2;

endmodule
`default_nettype wire

// File: tb/tb_rgb_ac1c2_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_ac1c2_seq
// Purpose  : Self-checking bench for rgb_ac1c2_seq: table of coefficient/pixel
//            vectors plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_ac1c2_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cfg_we;
  logic [3:0]  i_cfg_addr;
  logic [15:0] i_cfg_data;
  logic        o_cfg_err;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_R, i_G, i_B;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_A, o_C1, o_C2;
  logic        o_busy;

  rgb_ac1c2_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .o_cfg_err(o_cfg_err),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_A(o_A), .o_C1(o_C1), .o_C2(o_C2),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Edge counter and handshake recorders (values seen just before each edge).
  int cyc = 0;
  int acc_q[$];
  int out_cyc = 0;
  int err_pulses = 0;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_valid && o_ready) acc_q.push_back(cyc);
    if (o_valid && i_ready) out_cyc <= cyc;
    if (o_cfg_err) err_pulses <= err_pulses + 1;
  end

  typedef struct packed {
    logic [143:0] coefs;   // {m33,m32,m31,m23,m22,m21,m13,m12,m11}
    logic [7:0]   r, g, b;
    logic [31:0]  ea, ec1, ec2;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_busy"},  32'(o_busy),  32'd0);
    check({tag, "_err"},   32'(o_cfg_err), 32'd0);
    check({tag, "_A"},  o_A,  32'd0);
    check({tag, "_C1"}, o_C1, 32'd0);
    check({tag, "_C2"}, o_C2, 32'd0);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
    @(negedge i_clk);
    i_cfg_we = 1'b1; i_cfg_addr = addr; i_cfg_data = data;
    @(negedge i_clk);
    i_cfg_we = 1'b0;
    check("cfg_err_idle", 32'(o_cfg_err), 32'd0);
  endtask

  // Starts at the negedge just after the input handshake edge.
  task automatic finish_pixel(output int lat, output logic [31:0] a, c1, c2);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    a = o_A; c1 = o_C1; c2 = o_C2;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic present_pixel(input logic [7:0] r, g, b);
    int n;
    @(negedge i_clk);
    i_R = r; i_G = g; i_B = b; i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("ready_wait", 32'(n < 50), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] r, g, b, output int lat,
                            output logic [31:0] a, c1, c2);
    present_pixel(r, g, b);
    finish_pixel(lat, a, c1, c2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, n_acc, e0;
    logic [31:0] a, c1, c2, ca, cc1, cc2;

    vecs[0] = '{ {16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 16'h0003,16'h0002,16'h0001},
                 8'd10, 8'd20, 8'd30, 32'h0000_0460, 32'h0000_0000, 32'h0000_0000 };
    vecs[1] = '{ {16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'hFFFF, 16'h0003,16'h0002,16'h0001},
                 8'd10, 8'd20, 8'd30, 32'h0000_0460, 32'hFFFF_FFB0, 32'h0000_0000 };
    vecs[2] = '{ {16'h7FFF,16'h7FFF,16'h7FFF, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000},
                 8'd255, 8'd255, 8'd255, 32'h0000_0000, 32'h0000_0000, 32'hFBF3_E818 };
    vecs[3] = '{ {16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 16'h8000,16'h8000,16'h8000},
                 8'd255, 8'd255, 8'd255, 32'h040C_0000, 32'h0000_0000, 32'h0000_0000 };
    vecs[4] = '{ {16'h0001,16'hFF00,16'h0100, 16'h1000,16'hE000,16'h0000, 16'h0000,16'h0000,16'h2000},
                 8'd200, 8'd100, 8'd50, 32'h00C8_0000, 32'hFFB5_0000, 32'h0003_2190 };

    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0;
    i_valid = 1'b0; i_ready = 1'b0; i_R = '0; i_G = '0; i_B = '0;

    // Reset state and first-edge o_ready rise.
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst");
    i_rst_n = 1'b1;
    #1 check("rst_rel_ready_low", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    check("rst_rel_ready_high", 32'(o_ready), 32'd1);

    // Table-driven vectors: load full matrix, send pixel, check latency/results.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 9; j++) cfg_write(4'(j), vecs[i].coefs[j*16 +: 16]);
      send_pixel(vecs[i].r, vecs[i].g, vecs[i].b, lat, a, c1, c2);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
      check($sformatf("vec%0d_A", i),  a,  vecs[i].ea);
      check($sformatf("vec%0d_C1", i), c1, vecs[i].ec1);
      check($sformatf("vec%0d_C2", i), c2, vecs[i].ec2);
    end

    // Throughput: i_valid and i_ready held high, vec4 coefficients loaded.
    @(negedge i_clk);
    i_R = 8'd200; i_G = 8'd100; i_B = 8'd50; i_valid = 1'b1; i_ready = 1'b1;
    acc_q.delete();
    n = 0;
    while (acc_q.size() < 4 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    i_ready = 1'b0;
    check("thru_accepts", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() >= 4)
      for (int i = 1; i < 4; i++)
        check($sformatf("thru_period%0d", i), 32'(acc_q[i] - acc_q[i-1]), 32'd11);

    // Backpressure: result held for 5 cycles while the next pixel waits.
    n = 0;
    while (!o_valid && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    check("bp_valid", 32'(o_valid), 32'd1);
    ca = o_A; cc1 = o_C1; cc2 = o_C2;
    check("bp_A",  ca,  vecs[4].ea);
    check("bp_C1", cc1, vecs[4].ec1);
    check("bp_C2", cc2, vecs[4].ec2);
    n_acc = acc_q.size();
    repeat (5) begin
      @(negedge i_clk);
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_ready", 32'(o_ready), 32'd0);
      check("bp_hold_A",  o_A,  ca);
      check("bp_hold_C1", o_C1, cc1);
      check("bp_hold_C2", o_C2, cc2);
    end
    check("bp_no_accept", 32'(acc_q.size()), 32'(n_acc));
    i_ready = 1'b1;
    n = 0;
    while (acc_q.size() == n_acc && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b0;
    check("bp_accept_seen", 32'(acc_q.size() > n_acc), 32'd1);
    if (acc_q.size() > n_acc)
      check("bp_accept_after_idle", 32'(acc_q[n_acc] - out_cyc), 32'd1);
    finish_pixel(lat, a, c1, c2);
    check("bp_next_latency", 32'(lat), 32'd10);
    check("bp_next_A", a, vecs[4].ea);

    // Busy config rejection: write m11 during MAC.
    e0 = err_pulses;
    present_pixel(8'd200, 8'd100, 8'd50);
    @(negedge i_clk);
    i_cfg_we = 1'b1; i_cfg_addr = 4'd0; i_cfg_data = 16'h0010;
    @(negedge i_clk);
    i_cfg_we = 1'b0;
    check("busy_err_high", 32'(o_cfg_err), 32'd1);
    @(negedge i_clk);
    check("busy_err_low", 32'(o_cfg_err), 32'd0);
    finish_pixel(lat, a, c1, c2);
    check("busy_err_once", 32'(err_pulses - e0), 32'd1);
    check("busy_cur_A", a, vecs[4].ea);
    send_pixel(8'd200, 8'd100, 8'd50, lat, a, c1, c2);
    check("busy_next_A", a, vecs[4].ea);
    cfg_write(4'd0, 16'h0010);
    send_pixel(8'd200, 8'd100, 8'd50, lat, a, c1, c2);
    check("idle_write_A", a, 32'h0000_6400);
    check("idle_write_C1", c1, vecs[4].ec1);

    // Write and pixel acceptance in the same IDLE cycle.
    @(negedge i_clk);
    check("same_cycle_ready", 32'(o_ready), 32'd1);
    i_cfg_we = 1'b1; i_cfg_addr = 4'd0; i_cfg_data = 16'h0020;
    i_R = 8'd200; i_G = 8'd100; i_B = 8'd50; i_valid = 1'b1;
    @(negedge i_clk);
    i_cfg_we = 1'b0; i_valid = 1'b0;
    finish_pixel(lat, a, c1, c2);
    check("same_cycle_latency", 32'(lat), 32'd10);
    check("same_cycle_A", a, 32'h0000_C800);

    // Out-of-range address is ignored silently.
    cfg_write(4'd9, 16'hFFFF);
    send_pixel(8'd200, 8'd100, 8'd50, lat, a, c1, c2);
    check("addr9_A",  a,  32'h0000_C800);
    check("addr9_C2", c2, vecs[4].ec2);

    // Reset in the middle of MAC.
    present_pixel(8'd10, 8'd20, 8'd30);
    repeat (5) @(negedge i_clk);
    check("mid_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 check("midrst_rel_ready_low", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    check("midrst_rel_ready_high", 32'(o_ready), 32'd1);
    send_pixel(8'd10, 8'd20, 8'd30, lat, a, c1, c2);
    check("post_rst_latency", 32'(lat), 32'd10);
    check("post_rst_A",  a,  32'd0);
    check("post_rst_C1", c1, 32'd0);
    check("post_rst_C2", c2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
